// File: rtl/hurricane_scheduler_if.sv
// hurricane_scheduler_if
//   Groups the mode_fsm <-> hurricane_scheduler signals.
//   master : mode_fsm / power / keypad side; drives machine_state, mode_state, menu_btn.
//   slave  : hurricane_scheduler; drives enable/return decision, countdown and status.
// Signals
//   machine_state           1  1 = hood powered on
//   mode_state              3  current mode from mode_fsm (3'b011 = hurricane)
//   menu_btn                1  debounced menu button level
//   hurricane_mode_enabled  1  1 = gear 3 may be entered / held
//   return_state            1  valid when enabled=0: 1 = exit to gear 2, 0 = exit to standby
//   remaining_sec           8  seconds left in the active countdown, else 0
//   countdown_active        1  1 while the run or exit countdown is running
//   hurricane_used          1  1 once the grant has been consumed this power-on
interface hurricane_scheduler_if;
    logic       machine_state;
    logic [2:0] mode_state;
    logic       menu_btn;
    logic       hurricane_mode_enabled;
    logic       return_state;
    logic [7:0] remaining_sec;
    logic       countdown_active;
    logic       hurricane_used;

    modport master (
        output machine_state,
        output mode_state,
        output menu_btn,
        input  hurricane_mode_enabled,
        input  return_state,
        input  remaining_sec,
        input  countdown_active,
        input  hurricane_used
    );

    modport slave (
        input  machine_state,
        input  mode_state,
        input  menu_btn,
        output hurricane_mode_enabled,
        output return_state,
        output remaining_sec,
        output countdown_active,
        output hurricane_used
    );
endinterface

// File: rtl/hurricane_scheduler.sv
// hurricane_scheduler
//   Grants hurricane (gear 3, mode_state 3'b011) once per power-on, times the run, and tells
//   mode_fsm where to go when it ends: gear 2 on natural expiry, standby after a menu-requested
//   exit countdown. Also exports the seconds left for the display.
// Ports
//   clk    in  system clock
//   rst    in  asynchronous, active-low reset
//   sched  slave modport of hurricane_scheduler_if (all outputs registered)
// Parameters
//   CLK_HZ         clk cycles per second (1 Hz tick prescaler)
//   HURRICANE_SEC  hurricane run length, s (1..255)
//   RETURN_SEC     exit countdown after a menu press in hurricane, s (1..255)
//   REARM_SEC      standby seconds in LOCKED before re-grant (1..255), only with HURRICANE_REARM_EN
// Configuration
//   HURRICANE_REARM_EN  when defined, LOCKED re-arms after REARM_SEC consecutive standby seconds;
//                       when undefined, LOCKED is left only by powering off.
module hurricane_scheduler #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned HURRICANE_SEC = 60,
    parameter int unsigned RETURN_SEC    = 60,
    parameter int unsigned REARM_SEC     = 300
) (
    input logic                   clk,
    input logic                   rst,
    hurricane_scheduler_if.slave  sched
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PrescTop     = PW'(CLK_HZ - 1);
    localparam logic [2:0]    ModeHurricane = 3'b011;
    localparam logic [7:0]    HurrSec       = 8'(HURRICANE_SEC);
    localparam logic [7:0]    RetSec        = 8'(RETURN_SEC);

    // Elaboration-time range checks.
    if (CLK_HZ < 1) begin : gen_bad_clk_hz
        $error("CLK_HZ must be >= 1");
    end
    if (HURRICANE_SEC < 1 || HURRICANE_SEC > 255) begin : gen_bad_hurr_sec
        $error("HURRICANE_SEC must be 1..255");
    end
    if (RETURN_SEC < 1 || RETURN_SEC > 255) begin : gen_bad_ret_sec
        $error("RETURN_SEC must be 1..255");
    end
    if (REARM_SEC < 1 || REARM_SEC > 255) begin : gen_bad_rearm_sec
        $error("REARM_SEC must be 1..255");
    end

    typedef enum logic [2:0] {
        StReady,
        StRun,
        StExitWait,
        StExpireG2,
        StExpireSb,
        StLocked
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic          presc_clear;
    logic          tick;
    logic          menu_btn_q;
    logic          menu_edge;
    logic          enabled_q, enabled_d;
    logic          ret_q, ret_d;
    logic [7:0]    rem_q, rem_d;
    logic          active_q, active_d;
    logic          used_q, used_d;
    logic          hurr_mode;

`ifdef HURRICANE_REARM_EN
    localparam logic [7:0] RearmSec = 8'(REARM_SEC);
    logic [7:0] rearm_cnt_q, rearm_cnt_d;
`endif

    assign tick      = (presc_q == PrescTop);
    assign menu_edge = sched.menu_btn & ~menu_btn_q;
    assign hurr_mode = (sched.mode_state == ModeHurricane);

    // Free-running 1 Hz prescaler, restarted so each countdown gets full first seconds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (presc_clear || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        enabled_d   = enabled_q;
        ret_d       = ret_q;
        rem_d       = rem_q;
        used_d      = used_q;
        presc_clear = 1'b0;
`ifdef HURRICANE_REARM_EN
        rearm_cnt_d = '0;
`endif

        if (!sched.machine_state) begin
            state_d   = StReady;
            enabled_d = 1'b1;
            ret_d     = 1'b0;
            rem_d     = '0;
            used_d    = 1'b0;
        end else begin
            case (state_q)
                StReady: begin
                    enabled_d = 1'b1;
                    ret_d     = 1'b0;
                    if (hurr_mode) begin
                        state_d     = StRun;
                        rem_d       = HurrSec;
                        used_d      = 1'b1;
                        presc_clear = 1'b1;
                    end
                end
                StRun: begin
                    if (!hurr_mode) begin
                        // External abort: grant is consumed.
                        state_d   = StLocked;
                        enabled_d = 1'b0;
                        ret_d     = 1'b0;
                        rem_d     = '0;
                    end else if (tick && rem_q == 8'd1) begin
                        // Expiry wins over a coincident menu press.
                        state_d   = StExpireG2;
                        enabled_d = 1'b0;
                        ret_d     = 1'b1;
                        rem_d     = '0;
                    end else if (menu_edge) begin
                        state_d     = StExitWait;
                        rem_d       = RetSec;
                        presc_clear = 1'b1;
                    end else if (tick && rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                StExitWait: begin
                    if (!hurr_mode) begin
                        state_d   = StLocked;
                        enabled_d = 1'b0;
                        ret_d     = 1'b0;
                        rem_d     = '0;
                    end else if (tick && rem_q == 8'd1) begin
                        state_d   = StExpireSb;
                        enabled_d = 1'b0;
                        ret_d     = 1'b0;
                        rem_d     = '0;
                    end else if (tick && rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                StExpireG2, StExpireSb: begin
                    if (!hurr_mode) begin
                        state_d   = StLocked;
                        enabled_d = 1'b0;
                        ret_d     = 1'b0;
                        rem_d     = '0;
                        used_d    = 1'b1;
                    end
                end
                StLocked: begin
                    enabled_d = 1'b0;
                    ret_d     = 1'b0;
                    used_d    = 1'b1;
`ifdef HURRICANE_REARM_EN
                    // Only unbroken standby time counts toward re-arm.
                    if (sched.mode_state != 3'b000) begin
                        rearm_cnt_d = '0;
                    end else if (tick) begin
                        rearm_cnt_d = rearm_cnt_q + 8'd1;
                    end else begin
                        rearm_cnt_d = rearm_cnt_q;
                    end
                    if (rearm_cnt_d == RearmSec) begin
                        state_d     = StReady;
                        enabled_d   = 1'b1;
                        used_d      = 1'b0;
                        rem_d       = '0;
                        rearm_cnt_d = '0;
                    end else begin
                        rem_d = RearmSec - rearm_cnt_d;
                    end
`else
                    rem_d = '0;
`endif
                end
                default: begin
                    state_d   = StReady;
                    enabled_d = 1'b1;
                    ret_d     = 1'b0;
                    rem_d     = '0;
                    used_d    = 1'b0;
                end
            endcase
        end

        active_d = (state_d == StRun) || (state_d == StExitWait);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StReady;
            menu_btn_q <= 1'b0;
            enabled_q  <= 1'b1;
            ret_q      <= 1'b0;
            rem_q      <= '0;
            active_q   <= 1'b0;
            used_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            menu_btn_q <= sched.menu_btn;
            enabled_q  <= enabled_d;
            ret_q      <= ret_d;
            rem_q      <= rem_d;
            active_q   <= active_d;
            used_q     <= used_d;
        end
    end

`ifdef HURRICANE_REARM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rearm_cnt_q <= '0;
        end else begin
            rearm_cnt_q <= rearm_cnt_d;
        end
    end
`endif

    assign sched.hurricane_mode_enabled = enabled_q;
    assign sched.return_state           = ret_q;
    assign sched.remaining_sec          = rem_q;
    assign sched.countdown_active       = active_q;
    assign sched.hurricane_used         = used_q;

endmodule

// File: tb/tb_hurricane_scheduler.sv
// tb_hurricane_scheduler
//   Directed bench for hurricane_scheduler with CLK_HZ=10, HURRICANE_SEC=3, RETURN_SEC=2,
//   REARM_SEC=2. Stimulus pushes hand-computed expectations into a scoreboard queue; a monitor
//   on the falling edge pops and compares them against the DUT outputs.
module tb_hurricane_scheduler;

    logic clk;
    logic rst;

    hurricane_scheduler_if bus ();

    hurricane_scheduler #(
        .CLK_HZ       (10),
        .HURRICANE_SEC(3),
        .RETURN_SEC   (2),
        .REARM_SEC    (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sched(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       en;
        logic       ret;
        logic [7:0] rem;
        logic       act;
        logic       used;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

`ifdef HURRICANE_REARM_EN
    localparam logic [7:0] LockedRem = 8'd2;
`else
    localparam logic [7:0] LockedRem = 8'd0;
`endif

    task automatic expect_out(input string name, input logic en, input logic ret,
                              input logic [7:0] rem, input logic act, input logic used);
        exp_t e;
        e.name = name;
        e.en   = en;
        e.ret  = ret;
        e.rem  = rem;
        e.act  = act;
        e.used = used;
        sb_q.push_back(e);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every pending expectation away from the active edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (bus.hurricane_mode_enabled !== mon_e.en || bus.return_state !== mon_e.ret ||
                bus.remaining_sec !== mon_e.rem || bus.countdown_active !== mon_e.act ||
                bus.hurricane_used !== mon_e.used) begin
                errors++;
                $display("FAIL %s: got en=%0b ret=%0b rem=%0d act=%0b used=%0b, want en=%0b ret=%0b rem=%0d act=%0b used=%0b",
                         mon_e.name, bus.hurricane_mode_enabled, bus.return_state,
                         bus.remaining_sec, bus.countdown_active, bus.hurricane_used,
                         mon_e.en, mon_e.ret, mon_e.rem, mon_e.act, mon_e.used);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        bus.machine_state = 1'b0;
        bus.mode_state    = 3'b000;
        bus.menu_btn      = 1'b0;
        tick_n(2);
        expect_out("reset", 1, 0, 0, 0, 0);
        rst               = 1'b1;
        bus.machine_state = 1'b1;
        tick_n(1);
        expect_out("ready_idle", 1, 0, 0, 0, 0);

        // Natural expiry to gear 2, then lock.
        bus.mode_state = 3'b011;
        tick_n(1);
        expect_out("run_entry", 1, 0, 3, 1, 1);
        tick_n(9);
        expect_out("run_pre_tick", 1, 0, 3, 1, 1);
        tick_n(1);
        expect_out("run_tick1", 1, 0, 2, 1, 1);
        tick_n(19);
        expect_out("run_last_sec", 1, 0, 1, 1, 1);
        tick_n(1);
        expect_out("expire_g2", 0, 1, 0, 0, 1);
        tick_n(2);
        expect_out("expire_g2_hold", 0, 1, 0, 0, 1);
        bus.mode_state = 3'b010;
        tick_n(1);
        expect_out("locked", 0, 0, 0, 0, 1);
        bus.mode_state = 3'b011;
        tick_n(3);
        expect_out("locked_mode3", 0, 0, LockedRem, 0, 1);
        bus.mode_state = 3'b000;
        tick_n(20);
`ifdef HURRICANE_REARM_EN
        expect_out("rearm", 1, 0, 0, 0, 0);
`else
        expect_out("no_rearm", 0, 0, 0, 0, 1);
`endif

        bus.machine_state = 1'b0;
        tick_n(1);
        expect_out("power_off", 1, 0, 0, 0, 0);
        bus.machine_state = 1'b1;
        tick_n(1);

        // Menu-requested exit countdown to standby.
        bus.mode_state = 3'b011;
        tick_n(1);
        expect_out("run3_entry", 1, 0, 3, 1, 1);
        tick_n(11);
        expect_out("run3_clk11", 1, 0, 2, 1, 1);
        bus.menu_btn = 1'b1;
        tick_n(1);
        expect_out("exit_wait_entry", 1, 0, 2, 1, 1);
        bus.menu_btn = 1'b0;
        tick_n(9);
        expect_out("exit_wait_pre_tick", 1, 0, 2, 1, 1);
        tick_n(1);
        expect_out("exit_wait_tick", 1, 0, 1, 1, 1);
        bus.menu_btn = 1'b1;
        tick_n(1);
        bus.menu_btn = 1'b0;
        expect_out("menu_ignored", 1, 0, 1, 1, 1);
        tick_n(9);
        expect_out("expire_sb", 0, 0, 0, 0, 1);
        bus.mode_state = 3'b000;
        tick_n(1);
        expect_out("locked_sb", 0, 0, 0, 0, 1);
        bus.machine_state = 1'b0;
        tick_n(1);
        bus.machine_state = 1'b1;
        tick_n(1);

        // Power off mid-run.
        bus.mode_state = 3'b011;
        tick_n(1);
        expect_out("run4_entry", 1, 0, 3, 1, 1);
        tick_n(5);
        bus.machine_state = 1'b0;
        tick_n(1);
        expect_out("power_off_run", 1, 0, 0, 0, 0);
        bus.mode_state    = 3'b000;
        bus.machine_state = 1'b1;
        tick_n(1);

        // Menu edge on the final tick: expiry wins.
        bus.mode_state = 3'b011;
        tick_n(1);
        expect_out("run5_entry", 1, 0, 3, 1, 1);
        tick_n(29);
        expect_out("run5_last_sec", 1, 0, 1, 1, 1);
        bus.menu_btn = 1'b1;
        tick_n(1);
        expect_out("menu_vs_expiry", 0, 1, 0, 0, 1);
        bus.menu_btn = 1'b0;
        bus.mode_state    = 3'b000;
        bus.machine_state = 1'b0;
        tick_n(1);
        bus.machine_state = 1'b1;
        tick_n(1);

        // External abort during run.
        bus.mode_state = 3'b011;
        tick_n(5);
        expect_out("run6_mid", 1, 0, 3, 1, 1);
        bus.mode_state = 3'b001;
        tick_n(1);
        expect_out("abort_locked", 0, 0, 0, 0, 1);
        bus.mode_state    = 3'b000;
        bus.machine_state = 1'b0;
        tick_n(1);
        bus.machine_state = 1'b1;
        tick_n(1);

        // Asynchronous reset mid-run.
        bus.mode_state = 3'b011;
        tick_n(12);
        expect_out("run7_mid", 1, 0, 2, 1, 1);
        tick_n(1);
        rst = 1'b0;
        #2;
        expect_out("rst_async", 1, 0, 0, 0, 0);
        tick_n(1);
        bus.mode_state = 3'b000;
        rst            = 1'b1;
        tick_n(1);
        expect_out("after_rst", 1, 0, 0, 0, 0);

        tick_n(2);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
